// File: rtl/team_06_audio_pkg.sv
// team_06_audio_pkg: shared volume gain table and audio helpers
package team_06_audio_pkg;
  localparam logic [15:0][7:0] GAIN_LUT = {
    8'd255, 8'd189, 8'd139, 8'd103, 8'd76, 8'd55, 8'd40, 8'd29,
    8'd21, 8'd15, 8'd10, 8'd7, 8'd4, 8'd2, 8'd1, 8'd0
  };
  function automatic logic [7:0] gain_for(input logic [3:0] volume);
    return GAIN_LUT[volume];
  endfunction
  function automatic int unsigned mid(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction
endpackage

// File: rtl/team_06_gain_ramp.sv
// team_06_gain_ramp: steps the applied gain toward its target once per accepted sample
module team_06_gain_ramp #(
  parameter int RAMP_STEP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] target_i,
  input  logic       accept_i,
  input  logic       enable_i,
  output logic [7:0] gain_cur_o,
  output logic       ramp_busy_o
);
  localparam logic [7:0] STEP = 8'(RAMP_STEP);
  logic [7:0] gain_q, gain_d, diff, step;
  logic up;
  // Clamp the step to the remaining distance so the gain never overshoots; disable silences at once
  always_comb begin
    up = target_i > gain_q;
    diff = up ? target_i - gain_q : gain_q - target_i;
    step = diff > STEP ? STEP : diff;
    gain_d = !enable_i ? 8'd0 : !accept_i ? gain_q : up ? gain_q + step : gain_q - step;
  end
  // Gain register
  always_ff @(posedge clk) gain_q <= rst ? 8'd0 : gain_d;
  assign gain_cur_o = gain_q;
  assign ramp_busy_o = gain_q != target_i;
endmodule

// File: rtl/team_06_volume_ramp_scaler.sv
// team_06_volume_ramp_scaler: two-stage valid/ready log-volume scaler with zipper-free gain ramp
module team_06_volume_ramp_scaler #(
  parameter int DATA_W = 8,
  parameter int RAMP_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        volume,
  input  logic              mute,
  input  logic              enable_volume,
  output logic [DATA_W-1:0] out_sample,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        gain_cur,
  output logic              ramp_busy,
  output logic              en
);
  import team_06_audio_pkg::*;
  localparam int PW = DATA_W + 8;
  localparam logic [DATA_W-1:0] MID = DATA_W'(mid(DATA_W));
  logic s1_valid_q, s1_neg_q, out_valid_q, en_q;
  logic [DATA_W-1:0] s1_mag_q, out_sample_q;
  logic [7:0] s1_g_q, target, g_use;
  logic s2_adv, accept, in_neg;
  logic [DATA_W-1:0] in_mag, quo, scaled;
  logic [PW-1:0] prod;
  // Handshake, target selection, and split/recombine arithmetic around midscale
  always_comb begin
    s2_adv = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv;
    accept = in_valid && in_ready;
    target = (mute || !enable_volume) ? 8'd0 : gain_for(volume);
    g_use = enable_volume ? gain_cur : 8'd0;
    in_neg = in_sample < MID;
    in_mag = in_neg ? MID - in_sample : in_sample - MID;
    prod = PW'(s1_mag_q) * PW'(s1_g_q);
    quo = DATA_W'(prod / PW'(255));
    scaled = s1_neg_q ? MID - quo : MID + quo;
  end
  team_06_gain_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp (
    .clk(clk),
    .rst(rst),
    .target_i(target),
    .accept_i(accept),
    .enable_i(enable_volume),
    .gain_cur_o(gain_cur),
    .ramp_busy_o(ramp_busy)
  );
  // Stage 1: capture sign, magnitude and the pre-update gain of the accepted sample
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_neg_q <= 1'b0;
      s1_mag_q <= '0;
      s1_g_q <= 8'd0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      s1_neg_q <= in_neg;
      s1_mag_q <= in_mag;
      s1_g_q <= g_use;
    end
  // Stage 2: scaled output, held stable while downstream stalls
  always_ff @(posedge clk)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sample_q <= MID;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) out_sample_q <= scaled;
    end
  // Registered copy of the enable
  always_ff @(posedge clk) en_q <= rst ? 1'b0 : enable_volume;
  assign out_sample = out_sample_q;
  assign out_valid = out_valid_q;
  assign en = en_q;
endmodule

// File: tb/tb_team_06_volume_ramp_scaler.sv
// tb_team_06_volume_ramp_scaler: scoreboard bench with directed vectors for the volume scaler
module tb_team_06_volume_ramp_scaler;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] in_sample = 8'd0, in_sample2 = 8'd0;
  logic in_valid = 1'b0, in_valid2 = 1'b0, out_ready = 1'b1;
  logic [3:0] volume = 4'd0;
  logic mute = 1'b0, enable_volume = 1'b0;
  logic in_ready, out_valid, ramp_busy, en;
  logic in_ready2, out_valid2, ramp_busy2, en2;
  logic [7:0] out_sample, gain_cur, out_sample2, gain_cur2;
  int checks = 0, errors = 0;
  int exp_q[$], exp2_q[$];
  int t1_out [17] = '{128, 132, 137, 141, 146, 150, 155, 159, 164, 168, 173, 177, 182, 186, 191, 195, 200};

  team_06_volume_ramp_scaler #(.DATA_W(8), .RAMP_STEP(16)) dut (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .volume(volume), .mute(mute), .enable_volume(enable_volume),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .gain_cur(gain_cur), .ramp_busy(ramp_busy), .en(en)
  );
  team_06_volume_ramp_scaler #(.DATA_W(8), .RAMP_STEP(255)) dut2 (
    .clk(clk), .rst(rst), .in_sample(in_sample2), .in_valid(in_valid2), .in_ready(in_ready2),
    .volume(volume), .mute(mute), .enable_volume(enable_volume),
    .out_sample(out_sample2), .out_valid(out_valid2), .out_ready(1'b1),
    .gain_cur(gain_cur2), .ramp_busy(ramp_busy2), .en(en2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input bit b, input logic [7:0] x, input int e);
    if (b) begin in_sample2 = x; in_valid2 = 1'b1; exp2_q.push_back(e); end
    else begin in_sample = x; in_valid = 1'b1; exp_q.push_back(e); end
    for (int t = 0; ; t++) begin
      #1;
      if (b ? in_ready2 : in_ready) break;
      if (t == 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready 0 expected 1");
        if (b) void'(exp2_q.pop_back()); else void'(exp_q.pop_back());
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got %0d expected none", out_sample);
      end else chk("out_sample", out_sample, exp_q.pop_front());
    end
    if (!rst && out_valid2) begin
      if (exp2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out2_unexpected: got %0d expected none", out_sample2);
      end else chk("out_sample2", out_sample2, exp2_q.pop_front());
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 128);
    chk("rst_gain", gain_cur, 0);
    chk("rst_en", en, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    // ramp up at volume 15
    enable_volume = 1'b1;
    volume = 4'd15;
    @(negedge clk);
    #1;
    chk("en_follow", en, 1);
    chk("busy_start", ramp_busy, 1);
    for (int k = 1; k <= 17; k++) begin
      send(0, 8'd200, t1_out[k-1]);
      chk("t1_gain", gain_cur, k * 16 > 255 ? 255 : k * 16);
      chk("t1_busy", ramp_busy, k < 16 ? 1 : 0);
    end
    idle(4);
    // instant ramp instance
    send(1, 8'd128, 128);
    chk("t3_gain_instant", gain_cur2, 255);
    chk("t3_busy", ramp_busy2, 0);
    send(1, 8'd0, 0);
    send(1, 8'd255, 255);
    idle(4);
    // backpressure at unity gain
    out_ready = 1'b0;
    send(0, 8'd10, 10);
    send(0, 8'd20, 20);
    in_sample = 8'd30;
    in_valid = 1'b1;
    exp_q.push_back(30);
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_hold", out_sample, 10);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("bp_hold", out_sample, 10);
      chk("bp_in_ready_low", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_hold_release", out_sample, 10);
    chk("bp_in_ready_release", in_ready, 1);
    @(negedge clk);
    send(0, 8'd40, 40);
    send(0, 8'd50, 50);
    idle(4);
    // settle at volume 8 using midscale samples
    volume = 4'd8;
    for (int k = 0; k < 16; k++) send(0, 8'd128, 128);
    chk("t2_gain", gain_cur, 29);
    chk("t2_busy", ramp_busy, 0);
    idle(4);
    send(0, 8'd200, 136);
    in_valid = 1'b0;
    #1;
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_cycle2", out_valid, 1);
    chk("lat_value", out_sample, 136);
    send(0, 8'd56, 120);
    send(0, 8'd0, 114);
    send(0, 8'd128, 128);
    idle(4);
    // reset mid-ramp with output pending
    volume = 4'd15;
    for (int k = 0; k < 3; k++) send(0, 8'd128, 128);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_busy", ramp_busy, 1);
    @(negedge clk);
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sample", out_sample, 128);
    chk("mid_rst_gain", gain_cur, 0);
    chk("mid_rst_en", en, 0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_en", en, 1);
    // mute mid-ramp
    for (int k = 0; k < 6; k++) send(0, 8'd128, 128);
    chk("t5_gain96", gain_cur, 96);
    mute = 1'b1;
    idle(2);
    chk("t5_hold_no_accept", gain_cur, 96);
    chk("t5_busy", ramp_busy, 1);
    for (int k = 1; k <= 6; k++) begin
      send(0, 8'd128, 128);
      chk("t5_mute_gain", gain_cur, 96 - 16 * k);
    end
    chk("t5_mute_busy", ramp_busy, 0);
    mute = 1'b0;
    #1;
    chk("t5_unmute_busy", ramp_busy, 1);
    for (int k = 0; k < 16; k++) send(0, 8'd128, 128);
    chk("t5_unmute_gain", gain_cur, 255);
    chk("t5_unmute_busy_end", ramp_busy, 0);
    // enable dropped mid-stream
    send(0, 8'd200, 200);
    enable_volume = 1'b0;
    send(0, 8'd200, 128);
    chk("t6_gain_forced", gain_cur, 0);
    chk("t6_en_low", en, 0);
    send(0, 8'd60, 128);
    enable_volume = 1'b1;
    send(0, 8'd200, 128);
    chk("t6_fade_in", gain_cur, 16);
    send(0, 8'd200, 132);
    idle(1);
    for (int t = 0; t < 100 && (exp_q.size() != 0 || exp2_q.size() != 0); t++) @(negedge clk);
    chk("drain_left", exp_q.size() + exp2_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
